// File: rtl/mux8_arb.sv
// mux8_arb: round-robin arbiter/sequencer in front of the 8-input mux8.
// Picks one requester at a time, drives the mux select and holds it until
// the downstream consumer accepts the transfer (out_valid && out_ready).
//
// Optional feature macro: MUX8_ARB_LOCK_EN
//   defined   -> a requester with lock[i]=1 may keep the grant for up to
//                MAX_BURST consecutive transfers.
//   undefined -> lock is ignored, pure round-robin.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req[7:0]   in   request per mux input
//   lock[7:0]  in   burst-lock request per input (lock build only)
//   out_ready  in   downstream accepts current mux output
//   gnt[7:0]   out  registered one-hot grant, zero when idle
//   sel[2:0]   out  registered mux select, index of gnt (kept while idle)
//   out_valid  out  combinational: granted requester still requesting
//   busy       out  registered: a grant is held
module mux8_arb #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] lock,
  input  logic       out_ready,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       out_valid,
  output logic       busy
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned SW   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [SW-1:0] last;
  logic [SW-1:0] win_idle;
  logic [SW-1:0] win_done;
  logic          hold;

  // First set req bit searching from (from+1) upward, wrapping 7->0.
  function automatic logic [SW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [SW-1:0]   from);
    logic [SW-1:0] pick;
    logic          found;
    logic [SW-1:0] idx;
    pick  = from;
    found = 1'b0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = SW'(from + SW'(k));
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [SW-1:0] w);
    return NREQ'(1) << w;
  endfunction

  // From IDLE the search starts after the last completed requester; on a
  // completion it starts after the requester just finished.
  assign win_idle  = rr_pick(req, last);
  assign win_done  = rr_pick(req, sel);
  assign out_valid = (state == GRANT) && req[sel];
  assign busy      = (state == GRANT);

`ifdef MUX8_ARB_LOCK_EN
  localparam int unsigned BW = 4;
  logic [BW-1:0] burst_cnt;

  // Keep the same requester while it asks for lock and has burst budget left.
  assign hold = lock[sel] && (burst_cnt < BW'(MAX_BURST - 1));

  // Burst counter: counts extra transfers granted to a locked requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (state == GRANT) begin
      if (!req[sel]) begin
        burst_cnt <= '0;
      end else if (out_ready) begin
        burst_cnt <= hold ? BW'(burst_cnt + BW'(1)) : '0;
      end
    end
  end
`else
  logic [12:0] unused_cfg;
  assign unused_cfg = {lock, 5'(MAX_BURST)};
  assign hold       = 1'b0;
`endif

  // Arbiter FSM with registered grant/select.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      last  <= SW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= GRANT;
            sel   <= win_idle;
            gnt   <= onehot(win_idle);
          end
        end
        GRANT: begin
          if (!req[sel]) begin
            // Abandon: requester withdrew before completing.
            state <= IDLE;
            gnt   <= '0;
          end else if (out_ready && !hold) begin
            // Completion with re-arbitration in the same edge; req[sel] is
            // set here, so a winner always exists.
            last <= sel;
            sel  <= win_done;
            gnt  <= onehot(win_done);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_arb.sv
// Self-checking bench for mux8_arb: reference model feeds a scoreboard queue,
// plus directed sequence checks for rotation, backpressure, abandon, lock
// and mid-grant reset, followed by randomized traffic.
module tb_mux8_arb;

  localparam int unsigned MAX_BURST = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] lock;
  logic       out_ready;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       out_valid;
  logic       busy;

  mux8_arb #(.MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic       m_busy  = 1'b0;
  int         m_sel   = 0;
  int         m_last  = 7;
  int         m_burst = 0;
  logic       m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_ref(input logic [7:0] r, input int from);
    for (int k = 1; k <= 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return from;
  endfunction

  // One clock cycle: drive inputs, predict, clock, compare.
  task automatic cyc(input logic [7:0] r, input logic [7:0] l, input logic rdy,
                     input logic rn, output logic [2:0] got_sel);
    exp_t e;
    logic lock_en;
`ifdef MUX8_ARB_LOCK_EN
    lock_en = 1'b1;
`else
    lock_en = 1'b0;
`endif
    req = r; lock = l; out_ready = rdy; rst_n = rn;
    #1;
    if (m_known) check("out_valid_pre", 32'(out_valid), 32'(m_busy && r[m_sel]));
    // Model next state
    if (!rn) begin
      m_busy = 1'b0; m_sel = 0; m_last = 7; m_burst = 0;
    end else if (!m_busy) begin
      if (r != 8'h00) begin
        m_busy = 1'b1; m_sel = pick_ref(r, m_last);
      end
    end else if (!r[m_sel]) begin
      m_busy = 1'b0; m_burst = 0;
    end else if (rdy) begin
      if (lock_en && l[m_sel] && (m_burst < int'(MAX_BURST) - 1)) begin
        m_burst++;
      end else begin
        m_last = m_sel; m_burst = 0; m_sel = pick_ref(r, m_sel);
      end
    end
    e.busy = m_busy;
    e.sel  = 3'(m_sel);
    e.gnt  = m_busy ? (8'h01 << m_sel) : 8'h00;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (!rn) m_known = 1'b1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(1), 32'(0));
    end else begin
      e = sb_q.pop_front();
      if (m_known) begin
        check("gnt", 32'(gnt), 32'(e.gnt));
        check("sel", 32'(sel), 32'(e.sel));
        check("busy", 32'(busy), 32'(e.busy));
        check("out_valid_post", 32'(out_valid), 32'(e.busy && r[e.sel]));
      end
    end
    got_sel = sel;
    @(negedge clk);
  endtask

  logic [2:0] s;
  int lock_seq [10];

  initial begin
    req = '0; lock = '0; out_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);

    // Reset with all requests pending
    cyc(8'hFF, 8'h00, 1'b0, 1'b0, s);
    cyc(8'hFF, 8'h00, 1'b0, 1'b0, s);
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_sel", 32'(s), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    cyc(8'hFF, 8'h00, 1'b0, 1'b1, s);
    check("first_grant", 32'(s), 32'(0));

    // Full rotation, one transfer per cycle
    for (int i = 0; i < 8; i++) begin
      cyc(8'hFF, 8'h00, 1'b1, 1'b1, s);
      check("rotate_sel", 32'(s), 32'((i + 1) % 8));
      check("rotate_gnt", 32'(gnt), 32'(8'h01 << ((i + 1) % 8)));
    end
    cyc(8'h00, 8'h00, 1'b1, 1'b1, s);

    // Backpressure: sel 2 held, then 5
    cyc(8'h24, 8'h00, 1'b0, 1'b1, s);
    check("bp_grant", 32'(s), 32'(2));
    for (int i = 0; i < 3; i++) begin
      cyc(8'h24, 8'h00, 1'b0, 1'b1, s);
      check("bp_hold", 32'(s), 32'(2));
    end
    cyc(8'h24, 8'h00, 1'b1, 1'b1, s);
    check("bp_next", 32'(s), 32'(5));
    cyc(8'h00, 8'h00, 1'b0, 1'b1, s);

    // Abandon on sel 3
    cyc(8'h18, 8'h00, 1'b0, 1'b1, s);
    check("ab_grant", 32'(s), 32'(3));
    cyc(8'h10, 8'h00, 1'b0, 1'b1, s);
    check("ab_idle", 32'(busy), 32'(0));
    cyc(8'h10, 8'h00, 1'b0, 1'b1, s);
    check("ab_regrant", 32'(s), 32'(4));
    cyc(8'h10, 8'h00, 1'b1, 1'b1, s);
    check("b2b_sole", 32'(s), 32'(4));
    check("b2b_busy", 32'(busy), 32'(1));
    cyc(8'h00, 8'h00, 1'b0, 1'b1, s);

    // Lock burst
`ifdef MUX8_ARB_LOCK_EN
    lock_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
    lock_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
    cyc(8'h03, 8'h01, 1'b0, 1'b1, s);
    check("lock_0", 32'(s), 32'(lock_seq[0]));
    for (int i = 1; i < 10; i++) begin
      cyc(8'h03, 8'h01, 1'b1, 1'b1, s);
      check("lock_seq", 32'(s), 32'(lock_seq[i]));
    end
    cyc(8'h00, 8'h00, 1'b0, 1'b1, s);

    // Mid-grant reset
    cyc(8'h40, 8'h00, 1'b0, 1'b1, s);
    check("mr_grant", 32'(s), 32'(6));
    cyc(8'h41, 8'h00, 1'b0, 1'b0, s);
    check("mr_gnt", 32'(gnt), 32'(0));
    cyc(8'h41, 8'h00, 1'b0, 1'b1, s);
    check("mr_next", 32'(s), 32'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      cyc(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 49) != 0), s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
